pixel_unpacker: RTL and testbench

//  Sink for the threshold/brightness processor's word stream (in_vld/in_data/in_done).

---
 rtl/pixel_unpacker_pkg.sv | 7 +
 rtl/word_fifo.sv | 42 ++++
 rtl/pixel_unpacker.sv | 161 ++++++++++++++++
 tb/tb_pixel_unpacker.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_unpacker_pkg.sv
// Shared pixel geometry and FSM encoding for the pixel unpacker.
package pixel_unpacker_pkg;
  localparam int COLOR_SIZE = 8;
  localparam int PIXEL_SIZE = 3 * COLOR_SIZE;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/word_fifo.sv
// Synchronous word FIFO; extra pointer MSB distinguishes full from empty.
module word_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]           wptr_q, wptr_d, rptr_q, rptr_d;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, push};
    rptr_d = rptr_q + {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/pixel_unpacker.sv
// Buffers processor words and splits the LSB-first bit stream into pixels
// on a valid/ready port, tracking frame length, overflow and short frames.
module pixel_unpacker
  import pixel_unpacker_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_done,
  input  logic [15:0]           frame_pixels,
  input  logic                  pix_rdy,
  output logic                  pix_vld,
  output logic [PIXEL_SIZE-1:0] pix_data,
  output logic                  pix_last,
  output logic                  frame_done,
  output logic                  overflow,
  output logic                  short_err
);
  localparam int ACC_W  = DATA_WIDTH + PIXEL_SIZE;
  localparam int FILL_W = $clog2(ACC_W);
  localparam logic [FILL_W-1:0] PIX_F  = FILL_W'(PIXEL_SIZE);
  localparam logic [FILL_W-1:0] WORD_F = FILL_W'(DATA_WIDTH);

  state_t                state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [FILL_W-1:0]     fill_q, fill_d, fill_post;
  logic                  pix_vld_q, pix_vld_d, pix_last_q, pix_last_d;
  logic [PIXEL_SIZE-1:0] pix_data_q, pix_data_d;
  logic [15:0]           pix_cnt_q, pix_cnt_d, frame_px_q, frame_px_d;
  logic                  done_seen_q, done_seen_d, frame_done_q, frame_done_d;
  logic                  overflow_q, overflow_d, short_err_q, short_err_d;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  hs, emit, short_end;

  word_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (in_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign hs   = pix_vld_q & pix_rdy;
  // Once the frame's last pixel sits in the output register nothing more is loaded.
  assign emit = (state_q == RUN) && (fill_q >= PIX_F) && (!pix_vld_q || pix_rdy)
                && !(pix_vld_q && pix_last_q);
  // Refill decision uses post-emit fill so pop and emit overlap for 1 pixel/cycle.
  assign fill_post = emit ? fill_q - PIX_F : fill_q;
  assign fifo_pop  = !fifo_empty && (((state_q == RUN) && (fill_post < PIX_F)) || (state_q == DRAIN));
  assign fifo_push = in_vld && (!fifo_full || fifo_pop);
  assign short_end = done_seen_q && fifo_empty && (fill_q < PIX_F) && !pix_vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_vld) state_d = (frame_pixels == 16'd0) ? DRAIN : RUN;
      RUN:     if (hs && pix_last_q) state_d = DRAIN;
               else if (short_end)   state_d = IDLE;
      DRAIN:   if (done_seen_q && fifo_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d        = acc_q;
    fill_d       = fill_q;
    pix_vld_d    = pix_vld_q;
    pix_data_d   = pix_data_q;
    pix_last_d   = pix_last_q;
    pix_cnt_d    = pix_cnt_q + 16'(hs);
    frame_px_d   = frame_px_q;
    frame_done_d = 1'b0;
    short_err_d  = short_err_q;
    overflow_d   = overflow_q | (in_vld & fifo_full & !fifo_pop);
    done_seen_d  = done_seen_q | (in_done && (state_q != IDLE));
    if (hs) begin
      pix_vld_d  = 1'b0;
      pix_last_d = 1'b0;
    end
    case (state_q)
      IDLE: if (in_vld) begin
        frame_px_d   = frame_pixels;
        pix_cnt_d    = '0;
        frame_done_d = (frame_pixels == 16'd0);
      end
      RUN: begin
        if (emit) begin
          pix_vld_d  = 1'b1;
          pix_data_d = acc_q[PIXEL_SIZE-1:0];
          // Index of the pixel being loaded: handshakes so far plus one still held.
          pix_last_d = (pix_cnt_q + 16'(pix_vld_q)) == (frame_px_q - 16'd1);
        end
        acc_d  = (emit ? acc_q >> PIXEL_SIZE : acc_q)
               | (fifo_pop ? ACC_W'(fifo_rdata) << fill_post : '0);
        fill_d = fill_post + (fifo_pop ? WORD_F : '0);
        if (hs && pix_last_q) begin
          frame_done_d = 1'b1;
        end else if (short_end) begin
          frame_done_d = 1'b1;
          short_err_d  = 1'b1;
          fill_d       = '0;
          acc_d        = '0;
        end
      end
      DRAIN: begin
        acc_d  = '0;
        fill_d = '0;
      end
      default: ;
    endcase
    if (state_d == IDLE) done_seen_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q        <= '0;
      fill_q       <= '0;
      pix_vld_q    <= 1'b0;
      pix_data_q   <= '0;
      pix_last_q   <= 1'b0;
      pix_cnt_q    <= '0;
      frame_px_q   <= '0;
      done_seen_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      short_err_q  <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      pix_vld_q    <= pix_vld_d;
      pix_data_q   <= pix_data_d;
      pix_last_q   <= pix_last_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_px_q   <= frame_px_d;
      done_seen_q  <= done_seen_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      short_err_q  <= short_err_d;
    end
  end

  assign pix_vld    = pix_vld_q;
  assign pix_data   = pix_data_q;
  assign pix_last   = pix_last_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign short_err  = short_err_q;
endmodule

// File: tb/tb_pixel_unpacker.sv
// Scoreboard bench: 32-bit/depth-4 unpacker plus a 64-bit/depth-8 instance.
module tb_pixel_unpacker;
  import pixel_unpacker_pkg::*;

  typedef struct packed {logic [23:0] data; logic last;} exp_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_vld32 = 1'b0, in_vld64 = 1'b0, in_done = 1'b0, pix_rdy = 1'b0;
  logic [63:0] in_data = '0;
  logic [15:0] frame_pixels = '0;
  logic        pix_vld, pix_last, frame_done, overflow, short_err;
  logic [23:0] pix_data;
  logic        pix_vld64, pix_last64, frame_done64, overflow64, short_err64;
  logic [23:0] pix_data64;

  logic        rdy_mode = 1'b0, rdy_fixed = 1'b1;
  logic [3:0]  pat = 4'b1001;
  int          ph = 0, cyc = 0;
  logic [63:0] wbuf [8];
  exp_t        exp_q [$];
  int          total = 0, bad = 0, fd_cnt = 0, cap_cyc = 0, first_vld_cyc = 0;
  bit          vld_seen = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    pix_rdy = rdy_mode ? pat[ph] : rdy_fixed;
    if (rdy_mode) ph = (ph + 1) % 4;
  end

  pixel_unpacker #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld32), .in_data(in_data[31:0]), .in_done(in_done),
    .frame_pixels(frame_pixels), .pix_rdy(pix_rdy), .pix_vld(pix_vld), .pix_data(pix_data),
    .pix_last(pix_last), .frame_done(frame_done), .overflow(overflow), .short_err(short_err));

  pixel_unpacker #(.DATA_WIDTH(64), .FIFO_DEPTH(8)) dut64 (
    .clk(clk), .rst(rst), .in_vld(in_vld64), .in_data(in_data), .in_done(in_done),
    .frame_pixels(frame_pixels), .pix_rdy(pix_rdy), .pix_vld(pix_vld64), .pix_data(pix_data64),
    .pix_last(pix_last64), .frame_done(frame_done64), .overflow(overflow64), .short_err(short_err64));

  // Pixel i of the LSB-first concatenation of wbuf words of width ww.
  function automatic logic [23:0] stream_pix(input int i, input int ww);
    logic [255:0] s;
    logic [63:0]  m;
    s = '0;
    m = (ww == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
    for (int k = 0; k < 8; k++) s = s | (256'(wbuf[k] & m) << (k * ww));
    return s[i*24 +: 24];
  endfunction

  task automatic push_exp(input int fp, input int nw);
    int np;
    np = (nw * 32) / 24;
    if (np > fp) np = fp;
    for (int i = 0; i < np; i++) exp_q.push_back('{data: stream_pix(i, 32), last: (i == fp - 1)});
  endtask

  task automatic monitor();
    bit stall = 1'b0, chk_fd = 1'b0;
    logic [23:0] sd = '0;
    logic sl = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0; chk_fd = 1'b0;
      end else begin
        if (chk_fd) begin
          total++;
          if (frame_done !== 1'b1) begin bad++; $display("FAIL frame_done_after_last: got %b want 1", frame_done); end
          chk_fd = 1'b0;
        end
        if (stall) begin
          total++;
          if (pix_vld !== 1'b1 || pix_data !== sd || pix_last !== sl) begin
            bad++;
            $display("FAIL hold_stable: got vld=%b data=%h last=%b want vld=1 data=%h last=%b", pix_vld, pix_data, pix_last, sd, sl);
          end
        end
        if (frame_done) fd_cnt++;
        if (pix_vld && !vld_seen) begin vld_seen = 1'b1; first_vld_cyc = cyc; end
        if (pix_vld && pix_rdy) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL unexpected_pixel: got data=%h last=%b want none", pix_data, pix_last);
          end else begin
            e = exp_q.pop_front();
            if (pix_data !== e.data || pix_last !== e.last) begin
              bad++; $display("FAIL pixel: got data=%h last=%b want data=%h last=%b", pix_data, pix_last, e.data, e.last);
            end
          end
          if (pix_last) chk_fd = 1'b1;
        end
        stall = pix_vld && !pix_rdy;
        sd = pix_data; sl = pix_last;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_vld32 = 1'b0; in_vld64 = 1'b0; in_done = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic set_basic_words();
    wbuf[0] = 64'h33221100; wbuf[1] = 64'h77665544; wbuf[2] = 64'hBBAA9988;
    for (int k = 3; k < 8; k++) wbuf[k] = '0;
  endtask

  task automatic drive_words(input int nw, input bit wide);
    for (int k = 0; k < nw; k++) begin
      @(posedge clk); #1;
      if (k == 0) cap_cyc = cyc + 1;
      if (wide) in_vld64 = 1'b1; else in_vld32 = 1'b1;
      in_data = wbuf[k];
    end
    @(posedge clk); #1;
    in_vld32 = 1'b0; in_vld64 = 1'b0; in_done = 1'b1;
    @(posedge clk); #1;
    in_done = 1'b0;
  endtask

  task automatic wait_frame(input int fd0, input string name);
    int t = 0;
    while ((exp_q.size() != 0 || fd_cnt == fd0) && t < 300) begin @(negedge clk); t++; end
    total++;
    if (t >= 300) begin bad++; $display("FAIL %s_timeout: pending=%0d pulses=%0d want 0 and 1", name, exp_q.size(), fd_cnt - fd0); end
    repeat (4) @(negedge clk);
    total++;
    if (dut.state_q !== IDLE || fd_cnt != fd0 + 1) begin
      bad++; $display("FAIL %s_end: got state=%0d pulses=%0d want state=0 pulses=1", name, dut.state_q, fd_cnt - fd0);
    end
  endtask

  task automatic run_frame(input int fp, input int nw, input string name);
    int fd0;
    frame_pixels = 16'(fp);
    push_exp(fp, nw);
    fd0 = fd_cnt;
    vld_seen = 1'b0;
    drive_words(nw, 1'b0);
    wait_frame(fd0, name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({pix_vld, pix_data, pix_last, frame_done, overflow, short_err} !== '0) begin
      bad++; $display("FAIL reset_outputs: got vld=%b data=%h last=%b fd=%b ov=%b se=%b want all 0", pix_vld, pix_data, pix_last, frame_done, overflow, short_err);
    end
    total++;
    if ({pix_vld64, pix_data64, pix_last64, frame_done64, overflow64, short_err64} !== '0) begin
      bad++; $display("FAIL reset_outputs64: got vld=%b data=%h want 0", pix_vld64, pix_data64);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    set_basic_words();
    rdy_fixed = 1'b1;
    run_frame(4, 3, "basic");
    total++;
    if (overflow !== 1'b0 || short_err !== 1'b0) begin
      bad++; $display("FAIL basic_errors: got ov=%b se=%b want 0 0", overflow, short_err);
    end
  endtask

  task automatic test_backpressure();
    set_basic_words();
    ph = 0; rdy_mode = 1'b1;
    run_frame(4, 3, "backpressure");
    rdy_mode = 1'b0;
    total++;
    if (first_vld_cyc != cap_cyc + 2) begin
      bad++; $display("FAIL latency: got %0d cycles want 2", first_vld_cyc - cap_cyc);
    end
  endtask

  task automatic test_padding();
    set_basic_words();
    run_frame(3, 3, "padding");
    total++;
    if (short_err !== 1'b0 || pix_vld !== 1'b0) begin
      bad++; $display("FAIL padding_state: got se=%b vld=%b want 0 0", short_err, pix_vld);
    end
  endtask

  task automatic test_short();
    set_basic_words();
    run_frame(5, 3, "short");
    total++;
    if (short_err !== 1'b1 || overflow !== 1'b0) begin
      bad++; $display("FAIL short_err: got se=%b ov=%b want 1 0", short_err, overflow);
    end
  endtask

  task automatic test_overflow();
    int fd0;
    do_reset();
    rdy_fixed = 1'b0;
    frame_pixels = 16'd8;
    for (int k = 0; k < 8; k++) wbuf[k] = 64'(32'h03020100 + 32'(k) * 32'h04040404);
    push_exp(8, 6);
    fd0 = fd_cnt;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k == 6) begin
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL overflow_early: got %b want 0", overflow); end
      end
      if (k == 7) begin
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_set: got %b want 1", overflow); end
      end
      in_vld32 = 1'b1; in_data = wbuf[k];
    end
    @(posedge clk); #1;
    in_vld32 = 1'b0; in_done = 1'b1;
    @(posedge clk); #1;
    in_done = 1'b0; rdy_fixed = 1'b1;
    wait_frame(fd0, "overflow");
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    do_reset();
    rdy_fixed = 1'b0;
    set_basic_words();
    frame_pixels = 16'd4;
    drive_words(3, 1'b0);
    while (!pix_vld && t < 50) begin @(negedge clk); t++; end
    total++;
    if (pix_vld !== 1'b1) begin bad++; $display("FAIL mid_vld: got %b want 1", pix_vld); end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({pix_vld, pix_data, pix_last, frame_done, overflow, short_err} !== '0 || dut.state_q !== IDLE) begin
      bad++; $display("FAIL mid_reset: got vld=%b data=%h state=%0d want 0 0 0", pix_vld, pix_data, dut.state_q);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; rdy_fixed = 1'b1;
    run_frame(4, 3, "after_reset");
  endtask

  task automatic test_wide64();
    int n = 0, t = 0;
    do_reset();
    rdy_fixed = 1'b1;
    frame_pixels = 16'd5;
    wbuf[0] = 64'h7766554433221100; wbuf[1] = 64'hFFEEDDCCBBAA9988;
    for (int k = 2; k < 8; k++) wbuf[k] = '0;
    drive_words(2, 1'b1);
    while (n < 5 && t < 100) begin
      @(negedge clk); t++;
      if (pix_vld64 && pix_rdy) begin
        total++;
        if (pix_data64 !== stream_pix(n, 64) || pix_last64 !== (n == 4)) begin
          bad++; $display("FAIL wide_pixel%0d: got data=%h last=%b want data=%h last=%b", n, pix_data64, pix_last64, stream_pix(n, 64), (n == 4));
        end
        n++;
      end
    end
    total++;
    if (n != 5) begin bad++; $display("FAIL wide_count: got %0d want 5", n); end
    repeat (6) @(negedge clk);
    total++;
    if (dut64.state_q !== IDLE || pix_vld64 !== 1'b0 || short_err64 !== 1'b0) begin
      bad++; $display("FAIL wide_end: got state=%0d vld=%b se=%b want 0 0 0", dut64.state_q, pix_vld64, short_err64);
    end
  endtask

  initial begin
    fork monitor(); join_none
    test_reset();
    test_basic();
    test_backpressure();
    test_padding();
    test_short();
    test_overflow();
    test_reset_mid();
    test_wide64();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
